// File: rtl/ahb_arbiter_if.sv
// Arbiter-side bundle of an AHB-Lite bus arbiter.
//   hbusreq/hlock : per-master request and lock request
//   htrans/hburst : transfer/burst type of the current address-phase owner
//   hready        : bus-wide ready from the slave response mux
//   hgrant        : one-hot grant
//   hmaster       : address-phase owner index (master mux select)
//   hmaster_d     : data-phase owner index (read-data/response routing)
//   hmastlock     : current address phase is locked
interface ahb_arbiter_if #(
    parameter int unsigned NO_OF_MASTERS = 3,
    parameter int unsigned M_BITS        = $clog2(NO_OF_MASTERS)
);
    logic [NO_OF_MASTERS-1:0] hbusreq;
    logic [NO_OF_MASTERS-1:0] hlock;
    logic [1:0]               htrans;
    logic [2:0]               hburst;
    logic                     hready;
    logic [NO_OF_MASTERS-1:0] hgrant;
    logic [M_BITS-1:0]        hmaster;
    logic [M_BITS-1:0]        hmaster_d;
    logic                     hmastlock;

    // Arbiter view.
    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmaster_d, hmastlock
    );

    // Requester / bus-fabric view.
    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter with burst and lock protection.
//   hclk   : bus clock, rising edge
//   hreset : synchronous active-high reset
//   bus    : ahb_arbiter_if.slave (requests in, grant/owner indices out)
// Fixed-length bursts keep the grant until the second-to-last beat is
// accepted, so the next owner's address phase follows the last beat directly.
module ahb_arbiter #(
    parameter int unsigned NO_OF_MASTERS  = 3,
    parameter int unsigned M_BITS         = $clog2(NO_OF_MASTERS),
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb_arbiter_if.slave  bus
);
    localparam int unsigned REM_W = 4;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [NO_OF_MASTERS-1:0] DEFAULT_GRANT =
        NO_OF_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [M_BITS-1:0] DEFAULT_IDX = M_BITS'(DEFAULT_MASTER);

    logic [REM_W-1:0]         rem;
    logic [REM_W-1:0]         rem_next;
    logic [M_BITS-1:0]        owner;
    logic                     hold;
    logic [NO_OF_MASTERS-1:0] next_grant;

    // Index of the current grantee (grant is always one-hot).
    always_comb begin
        owner = '0;
        for (int i = 0; i < int'(NO_OF_MASTERS); i++) begin
            if (bus.hgrant[i]) owner = M_BITS'(i);
        end
    end

    // Remaining-beat tracking; INCR and SINGLE count as length 1.
    always_comb begin
        rem_next = '0;
        case (bus.htrans)
            TRANS_NONSEQ: begin
                case (bus.hburst[2:1])
                    2'b01:   rem_next = REM_W'(3);
                    2'b10:   rem_next = REM_W'(7);
                    2'b11:   rem_next = REM_W'(15);
                    default: rem_next = '0;
                endcase
            end
            TRANS_SEQ:  rem_next = (rem == '0) ? '0 : rem - REM_W'(1);
            TRANS_BUSY: rem_next = rem;
            TRANS_IDLE: rem_next = '0;
            default:    rem_next = '0;
        endcase
    end

    // Grant selection: hold for burst/lock, else round-robin after the grantee.
    always_comb begin
        logic                  found;
        logic [M_BITS-1:0]     idx;
        found      = 1'b0;
        idx        = '0;
        next_grant = DEFAULT_GRANT;
        hold       = (rem_next >= REM_W'(2)) ||
                     (bus.hlock[owner] && bus.hbusreq[owner]);
        for (int k = 1; k <= int'(NO_OF_MASTERS); k++) begin
            idx = M_BITS'((int'(owner) + k) % int'(NO_OF_MASTERS));
            if (!found && bus.hbusreq[idx]) begin
                next_grant      = '0;
                next_grant[idx] = 1'b1;
                found           = 1'b1;
            end
        end
        if (hold) next_grant = bus.hgrant;
    end

    // Pipeline registers; everything freezes while hready is low.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            bus.hgrant    <= DEFAULT_GRANT;
            bus.hmaster   <= DEFAULT_IDX;
            bus.hmaster_d <= DEFAULT_IDX;
            bus.hmastlock <= 1'b0;
            rem           <= '0;
        end else if (bus.hready) begin
            bus.hgrant    <= next_grant;
            bus.hmaster   <= owner;
            bus.hmaster_d <= bus.hmaster;
            bus.hmastlock <= bus.hlock[owner];
            rem           <= rem_next;
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round-robin, burst hold,
// wait states, lock, early termination and reset mid-burst.
module tb_ahb_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned MB = 2;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic hclk;
    logic hreset;
    int   n_checks;
    int   n_fail;

    ahb_arbiter_if #(.NO_OF_MASTERS(N), .M_BITS(MB)) bus ();

    ahb_arbiter #(.NO_OF_MASTERS(N), .M_BITS(MB), .DEFAULT_MASTER(0)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] lck,
                         input logic [1:0] tr, input logic [2:0] bu);
        bus.hbusreq = req;
        bus.hlock   = lck;
        bus.htrans  = tr;
        bus.hburst  = bu;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        hreset      = 1'b1;
        bus.hready  = 1'b1;
        drive(3'b111, 3'b000, IDLE, 3'b000);

        // Reset with everyone requesting
        tick(); tick();
        check("rst_grant", 8'(bus.hgrant), 8'h1);
        check("rst_master", 8'(bus.hmaster), 8'h0);
        check("rst_master_d", 8'(bus.hmaster_d), 8'h0);
        check("rst_lock", 8'(bus.hmastlock), 8'h0);
        hreset = 1'b0;
        tick();
        check("rst_release_grant", 8'(bus.hgrant), 8'h2);

        // Round-robin with SINGLE transfers
        drive(3'b111, 3'b000, NONSEQ, 3'b000);
        tick();
        check("rr1_grant", 8'(bus.hgrant), 8'h4);
        check("rr1_master", 8'(bus.hmaster), 8'h1);
        check("rr1_master_d", 8'(bus.hmaster_d), 8'h0);
        tick();
        check("rr2_grant", 8'(bus.hgrant), 8'h1);
        check("rr2_master", 8'(bus.hmaster), 8'h2);
        check("rr2_master_d", 8'(bus.hmaster_d), 8'h1);
        tick();
        check("rr3_grant", 8'(bus.hgrant), 8'h2);
        check("rr3_master", 8'(bus.hmaster), 8'h0);
        check("rr3_master_d", 8'(bus.hmaster_d), 8'h2);

        // Burst hold: master 1 takes the address phase, then INCR4
        drive(3'b010, 3'b000, IDLE, 3'b000);
        tick();
        check("b_setup_master", 8'(bus.hmaster), 8'h1);
        drive(3'b111, 3'b000, NONSEQ, 3'b011);
        tick();
        check("b_beat1_grant", 8'(bus.hgrant), 8'h2);
        bus.htrans = SEQ;
        tick();
        check("b_beat2_grant", 8'(bus.hgrant), 8'h2);
        tick();
        check("b_beat3_grant", 8'(bus.hgrant), 8'h4);
        check("b_beat3_master", 8'(bus.hmaster), 8'h1);
        tick();
        check("b_beat4_master", 8'(bus.hmaster), 8'h2);

        // Same INCR4 with a 3-cycle stall after beat 2
        drive(3'b010, 3'b000, IDLE, 3'b000);
        tick(); tick();
        check("w_setup_master", 8'(bus.hmaster), 8'h1);
        drive(3'b111, 3'b000, NONSEQ, 3'b011);
        tick();
        bus.htrans = SEQ;
        tick();
        check("w_beat2_grant", 8'(bus.hgrant), 8'h2);
        bus.hready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("w_stall_grant", 8'(bus.hgrant), 8'h2);
            check("w_stall_master", 8'(bus.hmaster), 8'h1);
            check("w_stall_master_d", 8'(bus.hmaster_d), 8'h1);
        end
        bus.hready = 1'b1;
        tick();
        check("w_beat3_grant", 8'(bus.hgrant), 8'h4);
        check("w_beat3_master", 8'(bus.hmaster), 8'h1);
        tick();
        check("w_beat4_master", 8'(bus.hmaster), 8'h2);
        check("w_beat4_grant", 8'(bus.hgrant), 8'h1);

        // Lock: master 0 keeps the bus for 5 SINGLE transfers
        drive(3'b111, 3'b001, NONSEQ, 3'b000);
        for (int s = 0; s < 5; s++) begin
            tick();
            check("l_grant", 8'(bus.hgrant), 8'h1);
            check("l_mastlock", 8'(bus.hmastlock), 8'h1);
        end
        bus.hlock = 3'b000;
        tick();
        check("l_release_grant", 8'(bus.hgrant), 8'h2);
        check("l_release_mastlock", 8'(bus.hmastlock), 8'h0);

        // Early termination of INCR8 by IDLE after beat 2
        drive(3'b010, 3'b000, IDLE, 3'b000);
        tick();
        drive(3'b111, 3'b000, NONSEQ, 3'b101);
        tick();
        check("e_beat1_grant", 8'(bus.hgrant), 8'h2);
        bus.htrans = SEQ;
        tick();
        check("e_beat2_grant", 8'(bus.hgrant), 8'h2);
        bus.htrans = IDLE;
        tick();
        check("e_idle_grant", 8'(bus.hgrant), 8'h4);

        // Locked INCR16 by master 2, reset at beat 5
        drive(3'b111, 3'b100, NONSEQ, 3'b111);
        tick();
        check("r_beat1_grant", 8'(bus.hgrant), 8'h4);
        check("r_beat1_master", 8'(bus.hmaster), 8'h2);
        bus.htrans = SEQ;
        tick(); tick(); tick();
        check("r_beat4_grant", 8'(bus.hgrant), 8'h4);
        check("r_beat4_mastlock", 8'(bus.hmastlock), 8'h1);
        hreset = 1'b1;
        tick();
        check("r_reset_grant", 8'(bus.hgrant), 8'h1);
        check("r_reset_master", 8'(bus.hmaster), 8'h0);
        check("r_reset_master_d", 8'(bus.hmaster_d), 8'h0);
        check("r_reset_mastlock", 8'(bus.hmastlock), 8'h0);
        // A stray SEQ after reset must not hold: the burst count was cleared
        hreset = 1'b0;
        drive(3'b111, 3'b000, SEQ, 3'b111);
        tick();
        check("r_after_grant", 8'(bus.hgrant), 8'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
